locked_aca_pipe: RTL and testbench

//  Parametrised, pipelined successor to the 32-bit key-locked almost-correct adder (ACA).
//  - Key loads serially over a handshake and is held in a register.
//  - Operands enter through a valid/ready stream and pass through a PIPE-stage pipeline.
//  - Per transaction, MODE selects approximate (windowed-carry) or exact addition.
//  - Wrong key bits deterministically corrupt sum bits.
//  - Saturating counters record approximation errors and key mismatches.
//  - Partial-key simulation studies use it as the drop-in locked arithmetic model.

---
 rtl/locked_aca_pipe.sv | 160 ++++++++++++++++
 tb/tb_locked_aca_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_aca_pipe.sv
// Key-locked almost-correct adder: a serially loaded key gates a valid/ready operand pipeline.
// Wrong key bits flip fixed result bits; counters track results that differ from the exact sum.
module locked_aca_pipe #(
  parameter int               WIDTH      = 32,
  parameter int               WINDOW     = 8,
  parameter int               KEY_W      = 64,
  parameter int               KEY_CHUNK  = 8,
  parameter int               PIPE       = 2,
  parameter logic [KEY_W-1:0] GOLDEN_KEY = '0,
  parameter int               CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 key_valid_i,
  input  logic [KEY_CHUNK-1:0] key_data_i,
  output logic                 key_ready_o,
  output logic                 key_done_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     add1_i,
  input  logic [WIDTH-1:0]     add2_i,
  input  logic                 mode_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH:0]       result_o,
  output logic                 approx_err_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic                 key_bad_o
);

  localparam int BEATS  = KEY_W / KEY_CHUNK;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LO_TOP = (WIDTH > WINDOW) ? WIDTH - WINDOW : 0;

  typedef enum logic [1:0] {K_IDLE, K_LOAD, K_RUN} kstate_e;

  kstate_e            r_state;
  logic [KEY_W-1:0]   r_key;
  logic [KEY_W-1:0]   w_key_next;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_key_ready;
  logic               r_key_done;
  logic               r_key_bad;
  logic               w_key_acc;
  logic               w_key_last;

  assign w_key_acc  = key_valid_i & r_key_ready;
  assign w_key_last = (r_beat == BEAT_W'(BEATS - 1));

  always_comb begin
    w_key_next = r_key;
    w_key_next[int'(r_beat)*KEY_CHUNK +: KEY_CHUNK] = key_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= K_IDLE;
      r_key       <= '0;
      r_beat      <= '0;
      r_key_ready <= 1'b0;
      r_key_done  <= 1'b0;
      r_key_bad   <= 1'b0;
    end else begin
      if (w_key_acc) begin
        r_key  <= w_key_next;
        r_beat <= w_key_last ? '0 : r_beat + 1'b1;
      end
      case (r_state)
        K_IDLE: begin
          r_key_ready <= 1'b1;
          if (key_valid_i) r_state <= K_LOAD;
        end
        K_LOAD:  r_key_ready <= 1'b1;
        default: ;
      endcase
      // The final beat commits the key and opens the operand path in one step.
      if (w_key_acc && w_key_last) begin
        r_state     <= K_RUN;
        r_key_ready <= 1'b0;
        r_key_done  <= 1'b1;
        r_key_bad   <= (w_key_next != GOLDEN_KEY);
      end
    end
  end

  logic [KEY_W-1:0] w_kdiff;
  logic [WIDTH:0]   w_flip;

  assign w_kdiff = r_key ^ GOLDEN_KEY;

  always_comb begin
    w_flip = '0;
    for (int k = 0; k < KEY_W; k++) begin
      w_flip[k % (WIDTH+1)] = w_flip[k % (WIDTH+1)] ^ w_kdiff[k];
    end
  end

  logic [WIDTH:0] w_aca;
  logic [WIDTH:0] w_exact;
  logic [WIDTH:0] w_res;
  logic           w_err;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_aca
      localparam int LO = (gi >= WINDOW) ? gi - WINDOW + 1 : 0;
      // Each sum bit only sees carries generated inside its own window.
      assign w_aca[gi] = 1'(({1'b0, add1_i[gi:LO]} + {1'b0, add2_i[gi:LO]}) >> (gi - LO));
    end
  endgenerate

  assign w_aca[WIDTH] = 1'(({1'b0, add1_i[WIDTH-1:LO_TOP]} + {1'b0, add2_i[WIDTH-1:LO_TOP]})
                          >> (WIDTH - LO_TOP));
  assign w_exact = {1'b0, add1_i} + {1'b0, add2_i};
  assign w_res   = (mode_i ? w_exact : w_aca) ^ w_flip;
  assign w_err   = (w_res != w_exact);

  logic               w_adv;
  logic [PIPE-1:0]    r_vld;
  logic [PIPE-1:0]    r_err;
  logic [WIDTH:0]     r_res [PIPE];
  logic [CNT_W-1:0]   r_err_cnt;

  assign w_adv = r_key_done & (~r_vld[PIPE-1] | out_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= '0;
      r_err <= '0;
      for (int s = 0; s < PIPE; s++) r_res[s] <= '0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid_i;
      r_err[0] <= in_valid_i & w_err;
      r_res[0] <= w_res;
      for (int s = 1; s < PIPE; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_err[s] <= r_err[s-1];
        r_res[s] <= r_res[s-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if (r_vld[PIPE-1] && out_ready_i && r_err[PIPE-1] && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign key_ready_o  = r_key_ready;
  assign key_done_o   = r_key_done;
  assign key_bad_o    = r_key_bad;
  assign in_ready_o   = w_adv;
  assign out_valid_o  = r_vld[PIPE-1];
  assign result_o     = r_res[PIPE-1];
  assign approx_err_o = r_err[PIPE-1];
  assign err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_locked_aca_pipe.sv
// Randomised and directed bench for locked_aca_pipe against a behavioural ACA/locking model.
// A queue scoreboard tracks in-flight results by the number of pipeline advances they have seen.
module tb_locked_aca_pipe;
  localparam int          WIDTH     = 32;
  localparam int          WINDOW    = 8;
  localparam int          KEY_W     = 64;
  localparam int          KEY_CHUNK = 8;
  localparam int          PIPE      = 2;
  localparam int          CNT_W     = 2;
  localparam logic [63:0] GOLDEN    = 64'h0;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 key_valid;
  logic [KEY_CHUNK-1:0] key_data;
  logic                 key_ready;
  logic                 key_done;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     add1;
  logic [WIDTH-1:0]     add2;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH:0]       result;
  logic                 approx_err;
  logic [CNT_W-1:0]     err_cnt;
  logic                 key_bad;

  int          checks = 0;
  int          failures = 0;
  int          n_deliv = 0;
  int          m_cnt = 0;
  logic [63:0] m_key = '0;

  typedef struct {
    logic [WIDTH:0] res;
    logic           err;
    int             age;
  } ent_t;
  ent_t q[$];

  locked_aca_pipe #(
    .WIDTH(WIDTH), .WINDOW(WINDOW), .KEY_W(KEY_W), .KEY_CHUNK(KEY_CHUNK),
    .PIPE(PIPE), .GOLDEN_KEY(GOLDEN), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .key_valid_i(key_valid), .key_data_i(key_data), .key_ready_o(key_ready), .key_done_o(key_done),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .add1_i(add1), .add2_i(add2), .mode_i(mode),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .approx_err_o(approx_err), .err_cnt_o(err_cnt), .key_bad_o(key_bad)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] m_exact(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint unsigned s;
    s = 64'(a) + 64'(b);
    return s[WIDTH:0];
  endfunction

  // Windowed sum straight from the definition: each bit is taken from its own short addition.
  function automatic logic [WIDTH:0] m_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic md, input logic [63:0] key);
    logic [WIDTH:0]  r;
    longint unsigned wa, wb, s, msk;
    int              top, lo, pos;
    if (md) begin
      r = m_exact(a, b);
    end else begin
      for (int i = 0; i <= WIDTH; i++) begin
        top = (i == WIDTH) ? WIDTH - 1 : i;
        lo  = (top - WINDOW + 1 < 0) ? 0 : top - WINDOW + 1;
        msk = (64'd1 << (top - lo + 1)) - 64'd1;
        wa  = (64'(a) >> lo) & msk;
        wb  = (64'(b) >> lo) & msk;
        s   = wa + wb;
        pos = (i == WIDTH) ? top - lo + 1 : i - lo;
        r[i] = s[pos];
      end
    end
    for (int k = 0; k < KEY_W; k++) begin
      if (key[k] != GOLDEN[k]) r[k % (WIDTH+1)] = ~r[k % (WIDTH+1)];
    end
    return r;
  endfunction

  always begin : p_cmp
    logic exp_ov;
    logic adv;
    ent_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
    end else begin
      exp_ov = (q.size() > 0) && (q[0].age >= PIPE);
      check("out_valid", out_valid, exp_ov);
      check("in_ready", in_ready, key_done & (~exp_ov | out_ready));
      check("err_cnt", err_cnt, m_cnt);
      if (key_done) check("key_bad_run", key_bad, m_key != GOLDEN);
      if (exp_ov) begin
        check("result", result, q[0].res);
        check("approx_err", approx_err, q[0].err);
      end
      adv = key_done & (~exp_ov | out_ready);
      if (exp_ov && out_ready) begin
        if (q[0].err && m_cnt < CNT_MAX) m_cnt++;
        void'(q.pop_front());
        n_deliv++;
      end
      if (adv) begin
        for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
        if (in_valid) begin
          e.res = m_sum(add1, add2, mode, m_key);
          e.err = (e.res != m_exact(add1, add2));
          e.age = 1;
          q.push_back(e);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_key_ready", key_ready, 0);
    check("rst_key_done", key_done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_approx_err", approx_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_key_bad", key_bad, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; key_valid = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_key(input logic [63:0] k);
    int t;
    m_key = k;
    for (int b = 0; b < KEY_W/KEY_CHUNK; b++) begin
      if ($urandom % 4 == 0) begin
        @(negedge clk);
        key_valid = 1'b0;
      end
      @(negedge clk);
      key_valid = 1'b1;
      key_data  = k[b*KEY_CHUNK +: KEY_CHUNK];
      #1;
      t = 0;
      while (!key_ready && t < 20) begin
        @(negedge clk);
        #1;
        t++;
      end
      check("key_ready_beat", key_ready, 1);
      if (b == KEY_W/KEY_CHUNK - 1) check("key_done_before_last", key_done, 0);
    end
    @(negedge clk);
    key_valid = 1'b0;
    #1;
    check("key_done", key_done, 1);
    check("key_ready_run", key_ready, 0);
    check("key_bad", key_bad, k != GOLDEN);
    check("in_ready_after_key", in_ready, 1);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic md);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; add1 = a; add2 = b; mode = md;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("send_accepted", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [WIDTH:0] er, input logic ee);
    int t = 0;
    #1;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({name, "_valid"}, out_valid, 1);
    check(name, result, er);
    check({name, "_err"}, approx_err, ee);
  endtask

  task automatic run_stream(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      add1      = $urandom;
      case ($urandom % 4)
        0:       add2 = $urandom;
        1:       add2 = ~add1;
        2:       add2 = ~add1 + 32'd1;
        default: add2 = 32'($urandom_range(0, 255));
      endcase
      mode = $urandom % 2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] bp_a [3];
    logic [WIDTH-1:0] bp_b [3];
    logic [63:0]      k;
    int               idx, d0, t;

    rst_n = 1'b0; key_valid = 1'b0; key_data = '0; in_valid = 1'b0;
    add1 = '0; add2 = '0; mode = 1'b0; out_ready = 1'b1;

    check("model_aca_ff_1", m_sum(32'hFF, 32'h1, 1'b0, 64'h0), 33'h0);
    check("model_exact_ff_1", m_sum(32'hFF, 32'h1, 1'b1, 64'h0), 33'h100);
    check("model_exact_max", m_sum(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0), 33'h1FFFFFFFE);
    check("model_key_bit3", m_sum(32'h1, 32'h1, 1'b1, 64'h8), 33'h00A);
    check("model_key_cancel", m_sum(32'h1, 32'h1, 1'b1, 64'h0000000800000004), 33'h002);

    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Operands offered before the key is loaded must be ignored.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; add1 = $urandom; add2 = $urandom;
      #1;
      check("in_ready_nokey", in_ready, 0);
      check("key_done_nokey", key_done, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;

    load_key(64'h0);
    send(32'hFF, 32'h1, 1'b0);
    expect_out("aca_ff_1", 33'h0, 1'b1);
    @(negedge clk);
    #1;
    check("err_cnt_first", err_cnt, 1);
    send(32'hFF, 32'h1, 1'b1);
    expect_out("exact_ff_1", 33'h100, 1'b0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    expect_out("exact_max", 33'h1FFFFFFFE, 1'b0);

    do_reset();
    load_key(64'h8);
    send(32'h1, 32'h1, 1'b1);
    expect_out("key_bit3", 33'h00A, 1'b1);

    do_reset();
    load_key(64'h0000000800000004);
    send(32'h1, 32'h1, 1'b1);
    expect_out("key_cancel", 33'h002, 1'b0);

    // Backpressure: three operands against a stalled output.
    do_reset();
    load_key(64'h0);
    for (int i = 0; i < 3; i++) begin
      bp_a[i] = $urandom;
      bp_b[i] = $urandom;
    end
    idx = 0;
    d0  = n_deliv;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (idx < 3);
      add1 = bp_a[(idx < 3) ? idx : 0];
      add2 = bp_b[(idx < 3) ? idx : 0];
      mode = 1'b0;
      #1;
      if (in_valid && in_ready) idx++;
    end
    check("bp_accepted", idx, 2);
    t = 0;
    while (idx < 3 && t < 20) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      add1 = bp_a[idx];
      add2 = bp_b[idx];
      #1;
      if (in_ready) idx++;
      t++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (PIPE + 3) @(negedge clk);
    check("bp_delivered", n_deliv - d0, 3);

    // Saturating counter with a 2-bit width.
    do_reset();
    load_key(64'h0);
    for (int i = 0; i < 5; i++) begin
      send(32'hFF, 32'h1, 1'b0);
      expect_out("sat_res", 33'h0, 1'b1);
    end
    @(negedge clk);
    #1;
    check("err_cnt_sat", err_cnt, 3);

    for (int it = 0; it < 6; it++) begin
      do_reset();
      case ($urandom % 3)
        0:       k = 64'h0;
        1:       k = 64'd1 << $urandom_range(0, 63);
        default: k = {$urandom, $urandom};
      endcase
      load_key(k);
      run_stream((it == 5) ? 40 : 150);
      if (it == 5) begin
        // Reset with results still in flight: nothing may emerge afterwards.
        do_reset();
        repeat (4) @(negedge clk);
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_key_done", key_done, 0);
      end else begin
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (PIPE + 3) @(negedge clk);
        #3;
        check("drain_empty", q.size(), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
